vinsn_issue_queue: RTL and testbench

Parametrised issue stage between `vinsn_decoder` and the execution back-end. Buffers up to `Depth` decoded `issue_req_t` entries and dispatches the head entry to two consumers: one VFU selected by opcode, and `vrf_accesser`. Each side is sent exactly once per entry. Hazard stall comes from an external scoreboard. Adds over the single-entry launcher: a real queue, per-entry skipping of the operand request, stall gating only before first dispatch, flush with head protection, and an occupancy output.

---
 rtl/core_pkg.sv | 81 ++++++++
 rtl/vinsn_issue_queue_fifo.sv | 70 +++++++
 rtl/vinsn_issue_queue.sv | 100 ++++++++++
 tb/tb_vinsn_issue_queue.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and decode helpers for the vector issue path.
package core_pkg;

    localparam int unsigned NrOps           = 3;
    localparam int unsigned VD              = 2;
    localparam int unsigned NrVFU           = 5;
    localparam int unsigned IssueQueueDepth = 4;

    typedef enum logic [3:0] {
        VADD, VSUB, VMUL, VMACC, VFADD, VLE, VSE, VSLIDEUP, VMAND
    } ara_op_e;

    typedef enum logic [2:0] {
        VFU_Alu, VFU_MFpu, VFU_LoadUnit, VFU_StoreUnit, VFU_SlideUnit
    } vfu_e;

    typedef enum logic [2:0] {
        OQ_None, OQ_Alu, OQ_MFpu, OQ_Store, OQ_Slide
    } op_queue_e;

    typedef logic [4:0] vreg_t;
    typedef logic [1:0] vew_t;

    typedef struct packed {
        ara_op_e                 vop;
        vreg_t [NrOps-1:0]       vs;
        vew_t  [NrOps-1:0]       vew;
        logic  [NrOps-1:0]       use_vs;
        logic  [7:0]             vl;
        logic  [7:0]             vstart;
        logic  [31:0]            scalar_op;
        logic  [2:0]             insn_id;
    } issue_req_t;

    typedef struct packed {
        ara_op_e                 vop;
        vew_t                    vew;
        logic  [7:0]             vl;
        logic  [NrOps-1:0]       use_vs;
        logic  [31:0]            scalar_op;
        logic  [2:0]             insn_id;
        vreg_t                   vd;
        logic  [7:0]             vstart;
    } vfu_req_t;

    typedef struct packed {
        vreg_t [NrOps-1:0]       vs;
        vew_t  [NrOps-1:0]       vew;
        op_queue_e               queue;
        logic  [7:0]             vl;
        logic  [7:0]             vstart;
    } op_req_t;

    function automatic vfu_e GetVFUByVOp(ara_op_e vop);
        vfu_e res;
        case (vop)
            VMUL, VMACC, VFADD: res = VFU_MFpu;
            VLE:                res = VFU_LoadUnit;
            VSE:                res = VFU_StoreUnit;
            VSLIDEUP:           res = VFU_SlideUnit;
            default:            res = VFU_Alu;
        endcase
        return res;
    endfunction

    function automatic op_queue_e GetOpQueue(ara_op_e vop, logic [NrOps-1:0] use_vs);
        op_queue_e res;
        if (use_vs == '0) begin
            res = OQ_None;
        end else begin
            case (vop)
                VMUL, VMACC, VFADD: res = OQ_MFpu;
                VSE:                res = OQ_Store;
                VSLIDEUP:           res = OQ_Slide;
                default:            res = OQ_Alu;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/vinsn_issue_queue_fifo.sv
// Generic typed circular buffer with occupancy count and keep-head flush.
module issue_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  T                data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic            keep_head_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o,
    output T                head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    T                mem_q [Depth];
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers/count; a keep-head flush rewinds the write pointer to just past the head.
    always_comb begin
        rptr_d = rptr_q + PtrW'(do_pop);
        wptr_d = wptr_q + PtrW'(do_push);
        cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
        if (flush_i) begin
            if (keep_head_i && !do_pop) begin
                wptr_d = rptr_q + PtrW'(1);
                cnt_d  = CntW'(1);
            end else begin
                wptr_d = rptr_d;
                cnt_d  = '0;
            end
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vinsn_issue_queue.sv
// Issue queue: buffers decoded instructions and dispatches the head once to
// its VFU and once to the operand requester, with stall and flush handling.
module vinsn_issue_queue
    import core_pkg::*;
#(
    parameter int unsigned Depth = IssueQueueDepth,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_req_valid_i,
    output logic             issue_req_ready_o,
    input  issue_req_t       issue_req_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [NrVFU-1:0] vfu_req_ready_i,
    output logic             vfu_req_valid_o,
    output vfu_e             target_vfu_o,
    output vfu_req_t         vfu_req_o,
    input  logic             op_req_ready_i,
    output logic             op_req_valid_o,
    output op_req_t          op_req_o,
    output logic             issued_o,
    output issue_req_t       issued_req_o,
    output logic [CntW-1:0]  count_o
);

    issue_req_t head;
    logic       full, empty, head_valid, push, pop, keep_head;
    logic       need_op, gate, vfu_fire, op_fire;
    logic       vfu_sent_q, vfu_sent_d, op_sent_q, op_sent_d;

    issue_fifo #(
        .T     (issue_req_t),
        .Depth (Depth),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .data_i      (issue_req_i),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .keep_head_i (keep_head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count_o),
        .head_o      (head)
    );

    // Dispatch handshakes; stall only holds back the first send of a head.
    always_comb begin
        issue_req_ready_o = ~full & ~flush_i & ~rst_i;
        push              = issue_req_valid_i & issue_req_ready_o;
        head_valid        = ~empty;
        need_op           = |head.use_vs;
        gate              = ~stall_i | vfu_sent_q | op_sent_q;
        target_vfu_o      = GetVFUByVOp(head.vop);
        vfu_req_valid_o   = head_valid & ~vfu_sent_q & gate;
        vfu_fire          = vfu_req_valid_o & vfu_req_ready_i[target_vfu_o];
        op_req_valid_o    = head_valid & need_op & ~op_sent_q & gate;
        op_fire           = op_req_valid_o & op_req_ready_i;
        pop               = head_valid & (vfu_sent_q | vfu_fire)
                                       & (op_sent_q | op_fire | ~need_op);
        keep_head         = (vfu_sent_q | op_sent_q) & ~pop;
        issued_o          = (vfu_fire | op_fire) & ~vfu_sent_q & ~op_sent_q;
        issued_req_o      = head;
        vfu_sent_d        = pop ? 1'b0 : (vfu_sent_q | vfu_fire);
        op_sent_d         = pop ? 1'b0 : (op_sent_q | op_fire);
    end

    // Field mapping from the head entry to both consumers.
    always_comb begin
        vfu_req_o.vop       = head.vop;
        vfu_req_o.vew       = head.vew[VD];
        vfu_req_o.vl        = head.vl;
        vfu_req_o.use_vs    = head.use_vs;
        vfu_req_o.scalar_op = head.scalar_op;
        vfu_req_o.insn_id   = head.insn_id;
        vfu_req_o.vd        = head.vs[VD];
        vfu_req_o.vstart    = head.vstart;
        op_req_o.vs         = head.vs;
        op_req_o.vew        = head.vew;
        op_req_o.queue      = GetOpQueue(head.vop, head.use_vs);
        op_req_o.vl         = head.vl;
        op_req_o.vstart     = head.vstart;
    end

    // Per-head sent flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vfu_sent_q <= 1'b0;
            op_sent_q  <= 1'b0;
        end else begin
            vfu_sent_q <= vfu_sent_d;
            op_sent_q  <= op_sent_d;
        end
    end

endmodule

// File: tb/tb_vinsn_issue_queue.sv
module tb_vinsn_issue_queue;
    import core_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    typedef struct packed {
        vfu_e     tgt;
        vfu_req_t req;
    } exp_vfu_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_req_valid_i;
    logic             issue_req_ready_o;
    issue_req_t       issue_req_i;
    logic             stall_i;
    logic             flush_i;
    logic [NrVFU-1:0] vfu_req_ready_i;
    logic             vfu_req_valid_o;
    vfu_e             target_vfu_o;
    vfu_req_t         vfu_req_o;
    logic             op_req_ready_i;
    logic             op_req_valid_o;
    op_req_t          op_req_o;
    logic             issued_o;
    issue_req_t       issued_req_o;
    logic [CntW-1:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    exp_vfu_t   exp_vfu [$];
    op_req_t    exp_op  [$];
    issue_req_t exp_iss [$];

    always #5 clk = ~clk;

    vinsn_issue_queue #(.Depth(Depth)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_req_valid_i (issue_req_valid_i),
        .issue_req_ready_o (issue_req_ready_o),
        .issue_req_i       (issue_req_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .vfu_req_ready_i   (vfu_req_ready_i),
        .vfu_req_valid_o   (vfu_req_valid_o),
        .target_vfu_o      (target_vfu_o),
        .vfu_req_o         (vfu_req_o),
        .op_req_ready_i    (op_req_ready_i),
        .op_req_valid_o    (op_req_valid_o),
        .op_req_o          (op_req_o),
        .issued_o          (issued_o),
        .issued_req_o      (issued_req_o),
        .count_o           (count_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got a handshake expected none", name);
    endtask

    function automatic issue_req_t mk(input ara_op_e op, input logic [2:0] use_vs, input logic [2:0] id);
        issue_req_t r;
        r.vop       = op;
        r.vs[0]     = 5'(id + 3'd1);
        r.vs[1]     = 5'(id) + 5'd10;
        r.vs[2]     = 5'(id) + 5'd20;
        r.vew[0]    = 2'd1;
        r.vew[1]    = 2'd2;
        r.vew[2]    = 2'(id);
        r.use_vs    = use_vs;
        r.vl        = 8'd16 + 8'(id);
        r.vstart    = 8'(id);
        r.scalar_op = 32'hA5A5_0000 | 32'(id);
        r.insn_id   = id;
        return r;
    endfunction

    // Pushes the entry and records what each consumer must later see.
    task automatic drive_push(input issue_req_t r, input vfu_e t, input op_queue_e q);
        exp_vfu_t e;
        op_req_t  o;
        issue_req_valid_i = 1'b1;
        issue_req_i       = r;
        e.tgt           = t;
        e.req.vop       = r.vop;
        e.req.vew       = r.vew[2];
        e.req.vl        = r.vl;
        e.req.use_vs    = r.use_vs;
        e.req.scalar_op = r.scalar_op;
        e.req.insn_id   = r.insn_id;
        e.req.vd        = r.vs[2];
        e.req.vstart    = r.vstart;
        exp_vfu.push_back(e);
        if (r.use_vs != 3'b000) begin
            o.vs     = r.vs;
            o.vew    = r.vew;
            o.queue  = q;
            o.vl     = r.vl;
            o.vstart = r.vstart;
            exp_op.push_back(o);
        end
        exp_iss.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every handshake the DUT presents.
    always @(negedge clk) begin
        if (!rst) begin
            if (vfu_req_valid_o && vfu_req_ready_i[target_vfu_o]) begin
                if (exp_vfu.size() == 0) unexpected("vfu_fire");
                else begin
                    exp_vfu_t e;
                    e = exp_vfu.pop_front();
                    chk("vfu_target", 128'(target_vfu_o), 128'(e.tgt));
                    chk("vfu_req", 128'(vfu_req_o), 128'(e.req));
                end
            end
            if (op_req_valid_o && op_req_ready_i) begin
                if (exp_op.size() == 0) unexpected("op_fire");
                else begin
                    op_req_t o;
                    o = exp_op.pop_front();
                    chk("op_req", 128'(op_req_o), 128'(o));
                end
            end
            if (issued_o) begin
                if (exp_iss.size() == 0) unexpected("issued");
                else begin
                    issue_req_t r;
                    r = exp_iss.pop_front();
                    chk("issued_req", 128'(issued_req_o), 128'(r));
                end
            end
        end
    end

    initial begin
        rst               = 1'b1;
        issue_req_valid_i = 1'b0;
        issue_req_i       = '0;
        stall_i           = 1'b0;
        flush_i           = 1'b0;
        vfu_req_ready_i   = '0;
        op_req_ready_i    = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 128'(issue_req_ready_o), 128'(0));
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_vfu_valid", 128'(vfu_req_valid_o), 128'(0));
        chk("rst_op_valid", 128'(op_req_valid_o), 128'(0));
        chk("rst_issued", 128'(issued_o), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(issue_req_ready_o), 128'(1));

        // Fill to capacity with no consumer ready, then refuse a fifth push
        drive_push(mk(VADD, 3'b011, 3'd0), VFU_Alu, OQ_Alu);        tick();
        drive_push(mk(VMUL, 3'b111, 3'd1), VFU_MFpu, OQ_MFpu);      tick();
        drive_push(mk(VSE, 3'b100, 3'd2), VFU_StoreUnit, OQ_Store); tick();
        drive_push(mk(VSLIDEUP, 3'b010, 3'd3), VFU_SlideUnit, OQ_Slide); tick();
        issue_req_i = mk(VMAND, 3'b011, 3'd7);
        @(negedge clk);
        chk("full_count", 128'(count_o), 128'(4));
        chk("full_ready", 128'(issue_req_ready_o), 128'(0));
        tick();
        issue_req_valid_i = 1'b0;
        @(negedge clk);
        chk("refused_count", 128'(count_o), 128'(4));

        // Drain one entry per cycle
        vfu_req_ready_i = '1;
        op_req_ready_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("drain_count", 128'(count_o), 128'(3 - i));
        end

        // Sustained push+pop keeps occupancy at one
        drive_push(mk(VFADD, 3'b011, 3'd4), VFU_MFpu, OQ_MFpu);      tick();
        @(negedge clk); chk("stream_count", 128'(count_o), 128'(1));
        drive_push(mk(VLE, 3'b000, 3'd5), VFU_LoadUnit, OQ_None);    tick();
        @(negedge clk); chk("stream_count", 128'(count_o), 128'(1));
        drive_push(mk(VSUB, 3'b001, 3'd6), VFU_Alu, OQ_Alu);         tick();
        @(negedge clk); chk("stream_count", 128'(count_o), 128'(1));
        issue_req_valid_i = 1'b0;
        tick();
        @(negedge clk); chk("stream_empty", 128'(count_o), 128'(0));

        // Operand side first, VFU side later
        vfu_req_ready_i = '0;
        drive_push(mk(VFADD, 3'b011, 3'd1), VFU_MFpu, OQ_MFpu); tick();
        issue_req_valid_i = 1'b0;
        @(negedge clk);
        chk("split_op_valid0", 128'(op_req_valid_o), 128'(1));
        chk("split_issued0", 128'(issued_o), 128'(1));
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("split_op_valid", 128'(op_req_valid_o), 128'(0));
            chk("split_issued", 128'(issued_o), 128'(0));
            chk("split_vfu_valid", 128'(vfu_req_valid_o), 128'(1));
        end
        tick();
        vfu_req_ready_i = '1;
        @(negedge clk);
        chk("split_late_issued", 128'(issued_o), 128'(0));
        tick();
        @(negedge clk); chk("split_pop", 128'(count_o), 128'(0));

        // Stall blocks the first dispatch only
        stall_i = 1'b1;
        drive_push(mk(VADD, 3'b001, 3'd2), VFU_Alu, OQ_Alu); tick();
        issue_req_valid_i = 1'b0;
        @(negedge clk);
        chk("stall_vfu_valid", 128'(vfu_req_valid_o), 128'(0));
        chk("stall_op_valid", 128'(op_req_valid_o), 128'(0));
        tick();
        stall_i         = 1'b0;
        vfu_req_ready_i = '0;
        @(negedge clk);
        chk("unstall_op_valid", 128'(op_req_valid_o), 128'(1));
        tick();
        stall_i         = 1'b1;
        vfu_req_ready_i = '1;
        @(negedge clk);
        chk("stall_partial_vfu", 128'(vfu_req_valid_o), 128'(1));
        tick();
        stall_i = 1'b0;
        @(negedge clk); chk("stall_partial_pop", 128'(count_o), 128'(0));

        // No source operands: VFU handshake alone retires the head
        drive_push(mk(VLE, 3'b000, 3'd3), VFU_LoadUnit, OQ_None); tick();
        issue_req_valid_i = 1'b0;
        @(negedge clk);
        chk("noop_op_valid", 128'(op_req_valid_o), 128'(0));
        chk("noop_issued", 128'(issued_o), 128'(1));
        tick();
        @(negedge clk); chk("noop_pop", 128'(count_o), 128'(0));

        // Flush with a partially dispatched head
        vfu_req_ready_i = '0;
        op_req_ready_i  = 1'b0;
        drive_push(mk(VSUB, 3'b011, 3'd4), VFU_Alu, OQ_Alu);    tick();
        drive_push(mk(VMACC, 3'b111, 3'd5), VFU_MFpu, OQ_MFpu); tick();
        drive_push(mk(VMAND, 3'b011, 3'd6), VFU_Alu, OQ_Alu);   tick();
        issue_req_valid_i = 1'b0;
        op_req_ready_i    = 1'b1;
        @(negedge clk);
        chk("fl_head_op_valid", 128'(op_req_valid_o), 128'(1));
        tick();
        op_req_ready_i = 1'b0;
        flush_i        = 1'b1;
        exp_op.delete();
        exp_iss.delete();
        while (exp_vfu.size() > 1) void'(exp_vfu.pop_back());
        @(negedge clk);
        chk("fl_ready", 128'(issue_req_ready_o), 128'(0));
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("fl_keep_count", 128'(count_o), 128'(1));
        chk("fl_keep_vfu_valid", 128'(vfu_req_valid_o), 128'(1));
        chk("fl_keep_op_valid", 128'(op_req_valid_o), 128'(0));
        tick();
        vfu_req_ready_i = '1;
        tick();
        vfu_req_ready_i = '0;
        @(negedge clk); chk("fl_keep_done", 128'(count_o), 128'(0));

        // Flush with no partial head empties the queue and refuses a push
        drive_push(mk(VADD, 3'b011, 3'd1), VFU_Alu, OQ_Alu);    tick();
        drive_push(mk(VMUL, 3'b111, 3'd2), VFU_MFpu, OQ_MFpu); tick();
        issue_req_i = mk(VSUB, 3'b001, 3'd3);
        flush_i     = 1'b1;
        exp_vfu.delete();
        exp_op.delete();
        exp_iss.delete();
        tick();
        issue_req_valid_i = 1'b0;
        flush_i           = 1'b0;
        @(negedge clk);
        chk("fl_empty_count", 128'(count_o), 128'(0));
        chk("fl_empty_vfu_valid", 128'(vfu_req_valid_o), 128'(0));

        // Asynchronous reset with two entries queued
        drive_push(mk(VADD, 3'b011, 3'd4), VFU_Alu, OQ_Alu);    tick();
        drive_push(mk(VMUL, 3'b111, 3'd5), VFU_MFpu, OQ_MFpu); tick();
        issue_req_valid_i = 1'b0;
        #2;
        chk("pre_arst_count", 128'(count_o), 128'(2));
        rst = 1'b1;
        #1;
        chk("arst_vfu_valid", 128'(vfu_req_valid_o), 128'(0));
        chk("arst_op_valid", 128'(op_req_valid_o), 128'(0));
        chk("arst_count", 128'(count_o), 128'(0));
        chk("arst_ready", 128'(issue_req_ready_o), 128'(0));
        exp_vfu.delete();
        exp_op.delete();
        exp_iss.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_arst_count", 128'(count_o), 128'(0));
        chk("post_arst_ready", 128'(issue_req_ready_o), 128'(1));

        // Every recorded expectation must have been consumed
        chk("left_vfu", 128'(exp_vfu.size()), 128'(0));
        chk("left_op", 128'(exp_op.size()), 128'(0));
        chk("left_iss", 128'(exp_iss.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
